shiftreg_sipo_collect: RTL and testbench

//  Serial-in parallel-out collector: the receive end of the multi-bit-word PISO stream.

---
 rtl/shiftreg_pkg.sv | 13 +
 rtl/shiftreg_sipo_collect_if.sv | 30 +++
 rtl/shiftreg_sipo_collect.sv | 83 ++++++++
 tb/tb_shiftreg_sipo_collect.sv | 137 +++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and helpers for the shift-register family.
package shiftreg_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } sipo_state_t;

    function automatic int cnt_width(input int nwords);
        return $clog2(nwords + 1);
    endfunction

endpackage

// File: rtl/shiftreg_sipo_collect_if.sv
// Word-stream input and parallel-vector output bundle of the SIPO collector.
interface shiftreg_sipo_collect_if
    import shiftreg_pkg::*;
#(
    parameter int nbits  = 8,
    parameter int nwords = 8
);
    localparam int CW = cnt_width(nwords);

    logic [nbits-1:0]             d;
    logic                         d_valid;
    logic                         d_ready;
    logic                         clr;
    logic [nwords-1:0][nbits-1:0] q_all;
    logic                         q_valid;
    logic                         q_ack;
    logic [CW-1:0]                count;

    // master is the producer/consumer environment, slave is the collector
    modport master (
        output d, d_valid, clr, q_ack,
        input  d_ready, q_all, q_valid, count
    );

    modport slave (
        input  d, d_valid, clr, q_ack,
        output d_ready, q_all, q_valid, count
    );

endinterface

// File: rtl/shiftreg_sipo_collect.sv
// Collects nwords serial words into a parallel vector; first word received lands at index 0.
module shiftreg_sipo_collect
    import shiftreg_pkg::*;
#(
    parameter int nbits  = 8,
    parameter int nwords = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    shiftreg_sipo_collect_if.slave  bus
);
    localparam int CW = cnt_width(nwords);
    localparam logic [CW-1:0] LAST_CNT = CW'(nwords - 1);

    generate
        if (nwords < 2) begin : g_bad_nwords
            $error("shiftreg_sipo_collect: nwords must be >= 2");
        end
    endgenerate

    sipo_state_t                  r_state, w_state;
    logic [CW-1:0]                r_count, w_count;
    logic [nwords-1:0][nbits-1:0] r_words, w_words;
    logic                         w_ready;
    logic                         w_accept;

    always_comb begin
        w_state  = r_state;
        w_count  = r_count;
        w_words  = r_words;
        w_ready  = (r_state == FILL) || ((r_state == FULL) && bus.q_ack);
        w_accept = bus.d_valid && w_ready;

        if (w_accept) begin
            for (int i = 0; i < nwords - 1; i++) begin
                w_words[i] = r_words[i+1];
            end
            w_words[nwords-1] = bus.d;
        end

        case (r_state)
            FILL: begin
                if (bus.clr) begin
                    w_count = w_accept ? CW'(1) : '0;
                end else if (w_accept) begin
                    w_count = r_count + CW'(1);
                    if (r_count == LAST_CNT) begin
                        w_state = FULL;
                    end
                end
            end
            FULL: begin
                // clr is deliberately ignored here: only q_ack releases a vector
                if (bus.q_ack) begin
                    w_count = w_accept ? CW'(1) : '0;
                    w_state = FILL;
                end
            end
            default: begin
                w_state = FILL;
                w_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_count <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_state;
            r_count <= w_count;
            r_words <= w_words;
        end
    end

    assign bus.d_ready = w_ready;
    assign bus.q_valid = (r_state == FULL);
    assign bus.q_all   = r_words;
    assign bus.count   = r_count;

endmodule

// File: tb/tb_shiftreg_sipo_collect.sv
// Directed vector bench for shiftreg_sipo_collect (nbits=8, nwords=4).
module tb_shiftreg_sipo_collect;

    localparam int NB = 8;
    localparam int NW = 4;

    typedef struct {
        logic        rst;
        logic [7:0]  d;
        logic        dValid;
        logic        clr;
        logic        qAck;
        logic        expQValid;
        logic [2:0]  expCount;
        logic        expDReady;
        logic        checkQ;
        logic [31:0] expQAll;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   testsRun = 0;
    int   testsFailed = 0;
    vec_t vecs[$];

    shiftreg_sipo_collect_if #(.nbits(NB), .nwords(NW)) bus ();

    shiftreg_sipo_collect #(.nbits(NB), .nwords(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic [7:0] d, input logic v, input logic c,
                          input logic a, input logic eqv, input logic [2:0] ecnt,
                          input logic edr, input logic chk, input logic [31:0] eq);
        vec_t t;
        t.rst = r; t.d = d; t.dValid = v; t.clr = c; t.qAck = a;
        t.expQValid = eqv; t.expCount = ecnt; t.expDReady = edr;
        t.checkQ = chk; t.expQAll = eq;
        vecs.push_back(t);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge happen, sample 1 time unit later
    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic v,
                                 input logic c, input logic a);
        @(negedge clk);
        rst = r; bus.d = d; bus.d_valid = v; bus.clr = c; bus.q_ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; bus.d = '0; bus.d_valid = 1'b0; bus.clr = 1'b0; bus.q_ack = 1'b0;

        //     rst d      v  clr ack  qv  cnt dr chk q_all
        addVec(1, 8'h00, 0, 0, 0,   0, 0, 1, 1, 32'h00000000);
        addVec(0, 8'h11, 1, 0, 0,   0, 1, 1, 0, 32'h0);
        addVec(0, 8'h22, 1, 0, 0,   0, 2, 1, 0, 32'h0);
        addVec(0, 8'h33, 1, 0, 0,   0, 3, 1, 0, 32'h0);
        addVec(0, 8'h44, 1, 0, 0,   1, 4, 0, 1, 32'h44332211);
        addVec(0, 8'h55, 1, 0, 1,   0, 1, 1, 1, 32'h55443322);
        addVec(0, 8'h66, 1, 0, 0,   0, 2, 1, 0, 32'h0);
        addVec(0, 8'h77, 1, 0, 0,   0, 3, 1, 0, 32'h0);
        addVec(0, 8'h88, 1, 0, 0,   1, 4, 0, 1, 32'h88776655);
        addVec(0, 8'h00, 0, 0, 1,   0, 0, 1, 0, 32'h0);
        addVec(0, 8'h01, 1, 0, 0,   0, 1, 1, 0, 32'h0);
        addVec(0, 8'h02, 1, 0, 0,   0, 2, 1, 0, 32'h0);
        addVec(0, 8'h00, 0, 1, 0,   0, 0, 1, 0, 32'h0);
        addVec(0, 8'hAA, 1, 0, 0,   0, 1, 1, 0, 32'h0);
        addVec(0, 8'hBB, 1, 0, 0,   0, 2, 1, 0, 32'h0);
        addVec(0, 8'hCC, 1, 0, 0,   0, 3, 1, 0, 32'h0);
        addVec(0, 8'hDD, 1, 0, 0,   1, 4, 0, 1, 32'hDDCCBBAA);
        for (int i = 0; i < 5; i++) begin
            addVec(0, 8'hEE, 1, 0, 0, 1, 4, 0, 1, 32'hDDCCBBAA);
        end
        addVec(0, 8'h00, 0, 0, 1,   0, 0, 1, 0, 32'h0);
        addVec(0, 8'h12, 1, 0, 0,   0, 1, 1, 0, 32'h0);
        addVec(0, 8'h34, 1, 0, 0,   0, 2, 1, 0, 32'h0);
        addVec(0, 8'h56, 1, 0, 0,   0, 3, 1, 0, 32'h0);
        addVec(1, 8'h78, 1, 0, 0,   0, 0, 1, 1, 32'h00000000);
        addVec(0, 8'h9A, 1, 1, 0,   0, 1, 1, 1, 32'h9A000000);
        addVec(0, 8'hBC, 1, 0, 0,   0, 2, 1, 0, 32'h0);
        addVec(0, 8'hDE, 1, 0, 0,   0, 3, 1, 0, 32'h0);
        addVec(0, 8'hF0, 1, 0, 0,   1, 4, 0, 1, 32'hF0DEBC9A);
        addVec(0, 8'h00, 0, 1, 0,   1, 4, 0, 1, 32'hF0DEBC9A);
        addVec(0, 8'h00, 0, 0, 1,   0, 0, 1, 0, 32'h0);
        addVec(0, 8'h00, 0, 0, 1,   0, 0, 1, 0, 32'h0);
        addVec(0, 8'hFF, 0, 0, 0,   0, 0, 1, 1, 32'hF0DEBC9A);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].d, vecs[k].dValid, vecs[k].clr, vecs[k].qAck);
            checkOutput($sformatf("v%0d_q_valid", k), 32'(bus.q_valid), 32'(vecs[k].expQValid));
            checkOutput($sformatf("v%0d_count", k), 32'(bus.count), 32'(vecs[k].expCount));
            checkOutput($sformatf("v%0d_d_ready", k), 32'(bus.d_ready), 32'(vecs[k].expDReady));
            if (vecs[k].checkQ) begin
                checkOutput($sformatf("v%0d_q_all", k), bus.q_all, vecs[k].expQAll);
            end
        end

        // Loopback: words of a PISO-loaded vector arrive with idle gaps between them
        begin
            logic [7:0] loaded [4];
            int sent = 0;
            int cycles = 0;
            loaded[0] = 8'h01; loaded[1] = 8'h02; loaded[2] = 8'h03; loaded[3] = 8'h04;
            while (!bus.q_valid && cycles < 50) begin
                if (sent < 4 && ((cycles % 2) == 0)) begin
                    applyStimulus(0, loaded[sent], 1, 0, 0);
                    sent++;
                end else begin
                    applyStimulus(0, 8'h5A, 0, 0, 0);
                end
                cycles++;
            end
            checkOutput("loop_q_valid_seen", 32'(bus.q_valid), 32'd1);
            checkOutput("loop_q_all", bus.q_all, 32'h04030201);
            checkOutput("loop_count", 32'(bus.count), 32'd4);
            applyStimulus(0, 8'h00, 0, 0, 1);
            checkOutput("loop_released", 32'(bus.q_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
